pc_flow_ctrl: RTL
=================

PC_FLOW_CTRL -- requirements
Module: pc_flow_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, return-stack entries, 2..16.
REQ-002 SHALL have parameter INTR_VECTOR, default 10'h3FF, interrupt service entry address.
REQ-003 SHALL have CLK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have OP  input  3  opcode: 0 NOP, 1 JMP, 2 BRCC, 3 CALL, 4 RET, 5 RETI, 6 SEI, 7 CLI.
REQ-006 SHALL have OP_VALID  input  1  OP/TARGET/COND are valid this cycle.
REQ-007 SHALL have TARGET  input  10  jump/branch/call destination.
REQ-008 SHALL have COND  input  1  branch condition for BRCC.
REQ-009 SHALL have INTR  input  1  level interrupt request.
REQ-010 SHALL have PC_COUNT  input  10  current program counter value.
REQ-011 SHALL have PC_LD  output  1  load request to program counter.
REQ-012 SHALL have PC_INC  output  1  increment request to program counter.
REQ-013 SHALL have PC_DIN  output  10  load value, meaningful only when PC_LD=1.
REQ-014 SHALL have INT_ACK  output  1  one-cycle pulse when the interrupt is taken.
REQ-015 SHALL have INT_EN  output  1  current interrupt-enable flag.
REQ-016 SHALL have STACK_ERR  output  1  sticky overflow/underflow flag.

Function
REQ-017 SHALL implement FSM states FETCH, EXEC, INTR; FETCH->EXEC unconditionally; PC_LD=PC_INC=0 in FETCH.
REQ-018 In EXEC with OP_VALID=0, SHALL stay in EXEC with PC_LD=PC_INC=0 (stall).
REQ-019 In EXEC with OP_VALID=1, SHALL assert exactly one of PC_LD/PC_INC for that cycle; PC_LD and PC_INC never both 1.
REQ-020 NOP, SEI, CLI, and BRCC with COND=0 SHALL assert PC_INC; SEI sets INT_EN, CLI clears INT_EN at the same edge.
REQ-021 JMP, and BRCC with COND=1, SHALL assert PC_LD with PC_DIN=TARGET.
REQ-022 CALL SHALL push return address and assert PC_LD with PC_DIN=TARGET; return address = PC_COUNT+1, except PC_COUNT=10'h3FF gives 10'h001.
REQ-023 RET SHALL pop top entry and assert PC_LD with PC_DIN=popped value; RETI does the same and sets INT_EN.
REQ-024 CALL with stack full SHALL drop the push, assert PC_INC instead of PC_LD, and set STACK_ERR.
REQ-025 RET/RETI with stack empty SHALL assert PC_INC, set STACK_ERR, and leave INT_EN unchanged.
REQ-026 After a completed EXEC (OP_VALID=1), next state SHALL be INTR if INTR=1, INT_EN=1 (value after this EXEC's update), and the stack is not full after this EXEC; otherwise FETCH.
REQ-027 In INTR, SHALL push PC_COUNT, assert PC_LD with PC_DIN=INTR_VECTOR, pulse INT_ACK, clear INT_EN, and go to FETCH.
REQ-028 A blocked interrupt (stack full or INT_EN=0) SHALL stay pending and be re-evaluated at every later EXEC completion; there is no latching of INTR.
REQ-029 STACK_ERR SHALL remain 1 until RST.
REQ-030 Stack pointer SHALL count 0..STACK_DEPTH; push and pop never occur in the same cycle.

Reset
REQ-031 While RST=1, SHALL force PC_LD=0, PC_INC=0, INT_ACK=0, and PC_DIN=0.
REQ-032 On an edge with RST=1: state=FETCH, INT_EN=0, STACK_ERR=0, stack empty; RST overrides any in-progress EXEC or INTR.

Structure
REQ-033 Package pc_flow_pkg SHALL hold the opcode enum, FSM state enum, PC width (10), and default INTR_VECTOR.
REQ-034 Return stack SHALL be sub-module pc_return_stack with push/pop/data-in/data-out/full/empty and synchronous RST.
REQ-035 pc_flow_ctrl SHALL contain the FSM, the return-address adder with wrap, and the interrupt-enable register; outputs are decoded combinationally from state and inputs.

Verification
REQ-036 Check reset: RST for 2 cycles -> PC_LD=PC_INC=0, INT_EN=0, STACK_ERR=0; first cycle after reset is FETCH.
REQ-037 Check CALL: PC_COUNT=10'h010, CALL TARGET=10'h200 -> PC_LD=1, PC_DIN=10'h200. Then RET -> PC_LD=1, PC_DIN=10'h011.
REQ-038 Check return-address wrap: PC_COUNT=10'h3FF, CALL, then RET -> PC_DIN=10'h001.
REQ-039 Check interrupt: SEI, INTR=1, PC_COUNT=10'h050 at INTR state -> INT_ACK pulse, PC_DIN=10'h3FF, INT_EN=0. Then RETI -> PC_DIN=10'h050, INT_EN=1.
REQ-040 Check overflow: 8 CALLs, then 9th CALL -> PC_INC=1, STACK_ERR=1. Then 8 RETs return addresses in LIFO order; 9th RET -> PC_INC=1.
REQ-041 Check stall and blocking: OP_VALID=0 for 3 cycles -> no PC_LD/PC_INC, state stays EXEC. INTR=1 with INT_EN=0 -> no INT_ACK.

Source files
------------

// File: rtl/pc_flow_pkg.sv
// Shared types and constants for the program-counter flow controller.
package pc_flow_pkg;

    localparam int PC_W = 10;
    localparam logic [PC_W-1:0] DEFAULT_INTR_VECTOR = 10'h3FF;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BRCC = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_RETI = 3'd5,
        OP_SEI  = 3'd6,
        OP_CLI  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_INTR  = 2'd2
    } state_e;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; push is ignored when full, pop when empty.
module pc_return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [SPW-1:0]   count
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;

    assign count = sp;
    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    assign dout  = empty ? '0 : mem[IDXW'(sp - 1'b1)];

    // sp points at the next free slot, so the top entry lives at sp-1
    always_ff @(posedge CLK) begin
        if (RST) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[IDXW'(sp)] <= din;
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Fetch/execute/interrupt sequencer that steers an external program counter
// and keeps a hardware return stack for CALL/RET and interrupt entry.
module pc_flow_ctrl
    import pc_flow_pkg::*;
#(
    parameter int              STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] INTR_VECTOR = DEFAULT_INTR_VECTOR
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [2:0]      OP,
    input  logic            OP_VALID,
    input  logic [PC_W-1:0] TARGET,
    input  logic            COND,
    input  logic            INTR,
    input  logic [PC_W-1:0] PC_COUNT,
    output logic            PC_LD,
    output logic            PC_INC,
    output logic [PC_W-1:0] PC_DIN,
    output logic            INT_ACK,
    output logic            INT_EN,
    output logic            STACK_ERR
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);

    state_e          state;
    op_e             op;
    logic            int_en;
    logic            int_en_nxt;
    logic            stack_err;
    logic            err_set;
    logic            full_after;
    logic            stack_push;
    logic            stack_pop;
    logic [PC_W-1:0] push_data;
    logic [PC_W-1:0] stack_dout;
    logic            stack_full;
    logic            stack_empty;
    logic [SPW-1:0]  stack_count;
    logic [PC_W-1:0] ret_addr;

    assign op = op_e'(OP);

    // Address 0 is never a legal return target, so the wrap skips to 1
    assign ret_addr = (PC_COUNT == 10'h3FF) ? 10'h001 : PC_COUNT + 10'd1;

    pc_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_stack (
        .CLK   (CLK),
        .RST   (RST),
        .push  (stack_push),
        .pop   (stack_pop),
        .din   (push_data),
        .dout  (stack_dout),
        .full  (stack_full),
        .empty (stack_empty),
        .count (stack_count)
    );

    always_comb begin
        PC_LD      = 1'b0;
        PC_INC     = 1'b0;
        PC_DIN     = '0;
        INT_ACK    = 1'b0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        push_data  = '0;
        int_en_nxt = int_en;
        err_set    = 1'b0;
        if (!RST) begin
            case (state)
                ST_EXEC: begin
                    if (OP_VALID) begin
                        case (op)
                            OP_JMP: begin
                                PC_LD  = 1'b1;
                                PC_DIN = TARGET;
                            end
                            OP_BRCC: begin
                                PC_LD  = COND;
                                PC_INC = !COND;
                                PC_DIN = COND ? TARGET : '0;
                            end
                            OP_CALL: begin
                                if (stack_full) begin
                                    PC_INC  = 1'b1;
                                    err_set = 1'b1;
                                end else begin
                                    stack_push = 1'b1;
                                    push_data  = ret_addr;
                                    PC_LD      = 1'b1;
                                    PC_DIN     = TARGET;
                                end
                            end
                            OP_RET, OP_RETI: begin
                                if (stack_empty) begin
                                    PC_INC  = 1'b1;
                                    err_set = 1'b1;
                                end else begin
                                    stack_pop = 1'b1;
                                    PC_LD     = 1'b1;
                                    PC_DIN    = stack_dout;
                                    if (op == OP_RETI) int_en_nxt = 1'b1;
                                end
                            end
                            OP_SEI: begin
                                PC_INC     = 1'b1;
                                int_en_nxt = 1'b1;
                            end
                            OP_CLI: begin
                                PC_INC     = 1'b1;
                                int_en_nxt = 1'b0;
                            end
                            default: PC_INC = 1'b1;
                        endcase
                    end
                end
                ST_INTR: begin
                    stack_push = !stack_full;
                    push_data  = PC_COUNT;
                    PC_LD      = 1'b1;
                    PC_DIN     = INTR_VECTOR;
                    INT_ACK    = 1'b1;
                    int_en_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Interrupt entry needs one free slot once this cycle's push/pop has landed
    always_comb begin
        if (stack_push)     full_after = (stack_count == SPW'(STACK_DEPTH - 1));
        else if (stack_pop) full_after = 1'b0;
        else                full_after = stack_full;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_FETCH;
            int_en    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            int_en <= int_en_nxt;
            if (err_set) stack_err <= 1'b1;
            case (state)
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    if (OP_VALID)
                        state <= (INTR && int_en_nxt && !full_after) ? ST_INTR : ST_FETCH;
                end
                ST_INTR:  state <= ST_FETCH;
                default:  state <= ST_FETCH;
            endcase
        end
    end

    assign INT_EN    = int_en;
    assign STACK_ERR = stack_err;

endmodule
